// File: rtl/data_memory_bank.sv
// rtl/data_memory_bank.sv - byte-enabled handshaked RAM with one-cycle response and zeroing sweep
module data_memory_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_req,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]       LAST_IDX = CW'(DEPTH - 1);
  // One extra bit so DEPTH == 2^ADDR_WIDTH is representable in the range compare
  localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_clr_addr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_error;

  logic                  w_accept;
  logic                  w_in_range;
  logic [CW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_cur;
  logic [DATA_WIDTH-1:0] w_merged;

  assign busy       = (r_state == S_CLEAR);
  assign req_ready  = (r_state == S_READY) && !clear_req;
  assign w_accept   = req_valid && req_ready;
  // The full address is compared, so out-of-range words never alias onto real ones
  assign w_in_range = ({1'b0, req_addr} < DEPTH_A);
  assign w_idx      = req_addr[CW-1:0];
  assign w_cur      = r_mem[w_idx];

  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_error  = r_rsp_error;

  // Merge enabled write lanes over the current word; reads ignore the byte enables
  always_comb begin
    w_merged = w_cur;
    for (int b = 0; b < NB; b++) begin
      if (req_write && req_be[b]) begin
        w_merged[8*b +: 8] = req_wdata[8*b +: 8];
      end
    end
  end

  // Sweep/serve controller: zero one word per cycle, then serve until a clear is requested
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_addr == LAST_IDX) begin
            r_state <= S_READY;
          end else begin
            r_clr_addr <= r_clr_addr + CW'(1);
          end
        end
        S_READY: begin
          if (clear_req) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
          end
        end
        default: begin
          r_state    <= S_CLEAR;
          r_clr_addr <= '0;
        end
      endcase
    end
  end

  // Array write port: sweep zeroes take the port in CLEAR, accepted in-range writes in READY
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_addr] <= '0;
    end else if (w_accept && req_write && w_in_range) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // Registered response: one strobe per accepted request, data/error hold otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rsp_error <= !w_in_range;
        r_rsp_rdata <= w_in_range ? w_merged : '0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_bank.sv
// tb/tb_data_memory_bank.sv - randomized bench with behavioural model for data_memory_bank
module tb_data_memory_bank;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear_req = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    req_be = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          busy;

  data_memory_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sweep as a count of words still to zero, memory as a plain array
  int            m_left = DEPTH;
  logic [DW-1:0] m_mem [DEPTH];
  logic          e_v = 1'b0;
  logic [DW-1:0] e_d = '0;
  logic          e_e = 1'b0;

  always @(posedge clk or negedge reset) begin
    logic          acc;
    logic [DW-1:0] w;
    if (!reset) begin
      m_left = DEPTH;
      e_v = 1'b0;
      e_d = '0;
      e_e = 1'b0;
    end else begin
      acc = (m_left == 0) && !clear_req && req_valid;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end
      end else if (clear_req) begin
        m_left = DEPTH;
      end
      if (acc) begin
        e_v = 1'b1;
        if (int'(req_addr) >= DEPTH) begin
          e_d = '0;
          e_e = 1'b1;
        end else begin
          w = m_mem[req_addr];
          if (req_write) begin
            if (req_be[0]) w[7:0]  = req_wdata[7:0];
            if (req_be[1]) w[15:8] = req_wdata[15:8];
            m_mem[req_addr] = w;
          end
          e_d = w;
          e_e = 1'b0;
        end
      end else begin
        e_v = 1'b0;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("req_ready", 32'(req_ready), 32'((m_left == 0) && !clear_req));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_v));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(e_d));
    chk("rsp_error", 32'(rsp_error), 32'(e_e));
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    cyc();
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      cyc();
      n++;
    end
    chk(name, 32'(n), 32'(DEPTH));
  endtask

  logic [DW-1:0] sdata [8];
  int pulses;

  initial begin
    #1 reset = 1'b0;
    repeat (3) cyc();
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    wait_ready("sweep_len_after_reset");

    // Fresh array reads zero
    req(1'b0, 8'd0, '0, 2'b00);
    chk("rd0_valid", 32'(rsp_valid), 32'd1);
    chk("rd0_data", 32'(rsp_rdata), 32'd0);
    req(1'b0, 8'd31, '0, 2'b00);
    chk("rd31_data", 32'(rsp_rdata), 32'd0);
    req(1'b0, 8'd63, '0, 2'b00);
    chk("rd63_err", 32'(rsp_error), 32'd0);

    // Byte-enable merge
    req(1'b1, 8'd5, 16'hABCD, 2'b11);
    chk("be_full_rsp", 32'(rsp_rdata), 32'hABCD);
    req(1'b1, 8'd5, 16'h1234, 2'b01);
    chk("be_low_rsp", 32'(rsp_rdata), 32'hAB34);
    req(1'b1, 8'd5, 16'hFFFF, 2'b00);
    chk("be_none_rsp", 32'(rsp_rdata), 32'hAB34);
    req(1'b0, 8'd5, 16'h0000, 2'b11);
    chk("be_readback", 32'(rsp_rdata), 32'hAB34);

    // Streaming writes then reads, no bubbles
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      sdata[i] = DW'($urandom);
      req(1'b1, AW'(i), sdata[i], 2'b11);
      if (rsp_valid) pulses++;
    end
    for (int i = 0; i < 8; i++) begin
      req(1'b0, AW'(i), '0, 2'b00);
      if (rsp_valid) pulses++;
      chk("stream_rd", 32'(rsp_rdata), 32'(sdata[i]));
    end
    chk("stream_pulses", 32'(pulses), 32'd16);

    // Out of range, no aliasing
    req(1'b1, 8'd64, 16'hFFFF, 2'b11);
    chk("oor_wr_err", 32'(rsp_error), 32'd1);
    chk("oor_wr_data", 32'(rsp_rdata), 32'd0);
    req(1'b0, 8'd200, '0, 2'b00);
    chk("oor_rd_err", 32'(rsp_error), 32'd1);
    req(1'b0, 8'd0, '0, 2'b00);
    chk("no_alias", 32'(rsp_rdata), 32'(sdata[0]));
    chk("no_alias_err", 32'(rsp_error), 32'd0);

    // Clear has priority; the held request goes through after the sweep
    req(1'b1, 8'd3, 16'h5555, 2'b11);
    clear_req = 1'b1;
    req(1'b0, 8'd3, '0, 2'b00);
    chk("clr_prio_not_acc", 32'(rsp_valid), 32'd0);
    clear_req = 1'b0;
    wait_ready("sweep_len_after_clear");
    cyc();
    chk("held_acc_valid", 32'(rsp_valid), 32'd1);
    chk("held_rd3", 32'(rsp_rdata), 32'd0);
    idle();

    // Randomized traffic with occasional clears
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = $urandom_range(0, 1) == 1;
      req_addr  = ($urandom_range(0, 15) == 0) ? AW'($urandom) : AW'($urandom_range(0, 67));
      req_wdata = DW'($urandom);
      req_be    = 2'($urandom);
      clear_req = ($urandom_range(0, 99) == 0);
      cyc();
    end
    idle();
    repeat (DEPTH + 2) cyc();

    // Reset mid-sweep drops held response data and restarts the sweep
    req(1'b1, 8'd9, 16'hBEEF, 2'b11);
    chk("pre_reset_wr", 32'(rsp_rdata), 32'hBEEF);
    req_valid = 1'b0;
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    repeat (20) cyc();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd1);
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    repeat (3) cyc();
    reset = 1'b1;
    wait_ready("sweep_len_after_midreset");
    req(1'b0, 8'd9, '0, 2'b00);
    chk("post_sweep_rd9", 32'(rsp_rdata), 32'd0);
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
